// File: rtl/aes_tiled_pkg.sv
// Shared definitions for the tiled AES lane datapath: FSM encoding, op decode,
// job-to-byte routing and the GF(2^8) primitives used by every lane.
package aes_tiled_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;
   typedef enum logic [1:0] {OP_SBSR, OP_SB, OP_MIX} op_t;

   // col[i] selects one of the 8 source bytes ({rs2, rs1}, rs1 byte 0 = index 0).
   // S-box ops use col[0] only; MIX uses all four as {c3,c2,c1,c0}.
   typedef struct packed {
      logic [3:0][2:0] col;
      logic [1:0]      pos;
   } bsel_t;

   function automatic bit lanes_legal(input int lanes);
      return (lanes == 1) || (lanes == 2) || (lanes == 4);
   endfunction

   function automatic op_t op_decode(input logic mix, input logic sb, input logic sbsr);
      casez ({mix, sb, sbsr})
         3'b1??:  return OP_MIX;
         3'b01?:  return OP_SB;
         default: return OP_SBSR;
      endcase
   endfunction

   function automatic bsel_t job_sel(input op_t op, input logic dec, input logic hi,
                                     input logic [1:0] job);
      bsel_t           s;
      logic [3:0][2:0] t;
      s.pos = job;
      s.col = '0;
      t     = '0;
      case (op)
         OP_MIX: begin
            case (job)
               2'd0:    s.col = {3'd0, 3'd1, 3'd4, 3'd5};
               2'd1:    s.col = {3'd1, 3'd4, 3'd5, 3'd0};
               2'd2:    s.col = {3'd2, 3'd3, 3'd6, 3'd7};
               default: s.col = {3'd3, 3'd6, 3'd7, 3'd2};
            endcase
         end
         OP_SB: s.col[0] = {1'b0, job};
         default: begin
            case ({dec, hi})
               2'b00:   t = {3'd1, 3'd2, 3'd7, 3'd0};
               2'b01:   t = {3'd5, 3'd6, 3'd3, 3'd4};
               2'b10:   t = {3'd5, 3'd2, 3'd3, 3'd0};
               default: t = {3'd1, 3'd6, 3'd7, 3'd4};
            endcase
            s.col[0] = t[job];
         end
      endcase
      return s;
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Multiplicative inverse as x^254 through a short addition chain.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] x2, x3, x12, x15, x240;
      x2   = gf_mul(x, x);
      x3   = gf_mul(x2, x);
      x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
      x15  = gf_mul(x12, x3);
      x240 = gf_mul(x15, x15);
      x240 = gf_mul(x240, x240);
      x240 = gf_mul(x240, x240);
      x240 = gf_mul(x240, x240);
      return gf_mul(gf_mul(x240, x12), x2);
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      logic [15:0] t;
      t = {b, b} << n;
      return t[15:8];
   endfunction

   function automatic logic [7:0] aes_fwd_sbox(input logic [7:0] x);
      logic [7:0] i;
      i = gf_inv(x);
      return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] aes_inv_sbox(input logic [7:0] s);
      return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
   endfunction

   function automatic logic [7:0] aes_mixcolumn_byte(input logic [31:0] col, input logic inv);
      logic [7:0] c0, c1, c2, c3;
      {c3, c2, c1, c0} = col;
      if (inv)
         return gf_mul(c0, 8'h0e) ^ gf_mul(c1, 8'h0b) ^ gf_mul(c2, 8'h0d) ^ gf_mul(c3, 8'h09);
      return xtime(c0) ^ xtime(c1) ^ c1 ^ c2 ^ c3;
   endfunction

endpackage

// File: rtl/aes_tiled_lane.sv
// One byte lane: routes the job's source bytes from the latched operands and
// produces a single S-box or MixColumn result byte.
module aes_tiled_lane
   import aes_tiled_pkg::*;
#(
   parameter bit DECRYPT_EN = 1'b1
) (
   input  logic [31:0] rs1_i,
   input  logic [31:0] rs2_i,
   input  op_t         op_i,
   input  logic        dec_i,
   input  logic        hi_i,
   input  logic [1:0]  job_i,
   output logic [7:0]  byte_o,
   output logic [1:0]  pos_o
);

   logic [7:0][7:0] src;
   bsel_t           sel;
   logic [31:0]     col;
   logic [7:0]      fwd_b, inv_b, mix_b;

   assign src   = {rs2_i, rs1_i};
   assign sel   = job_sel(op_i, dec_i, hi_i, job_i);
   assign col   = {src[sel.col[3]], src[sel.col[2]], src[sel.col[1]], src[sel.col[0]]};
   assign pos_o = sel.pos;

   assign fwd_b = aes_fwd_sbox(col[7:0]);
   assign mix_b = aes_mixcolumn_byte(col, dec_i);

   if (DECRYPT_EN) begin : g_inv
      assign inv_b = aes_inv_sbox(col[7:0]);
   end else begin : g_no_inv
      assign inv_b = fwd_b;
   end

   always_comb begin
      byte_o = fwd_b;
      case (op_i)
         OP_MIX:  byte_o = mix_b;
         OP_SB:   byte_o = fwd_b;
         default: byte_o = dec_i ? inv_b : fwd_b;
      endcase
   end

endmodule

// File: rtl/aes_tiled_lanes.sv
// AES SB / SBSR / MIX coprocessor datapath with LANES byte units per cycle;
// result lands in rd only when all four bytes of a job set are done.
module aes_tiled_lanes
   import aes_tiled_pkg::*;
#(
   parameter int LANES      = 1,
   parameter bit DECRYPT_EN = 1'b1
) (
   input  logic        g_clk,
   input  logic        g_resetn,
   input  logic        valid,
   input  logic        flush,
   input  logic        dec,
   input  logic        op_sb,
   input  logic        op_sbsr,
   input  logic        op_mix,
   input  logic        hi,
   input  logic [31:0] rs1,
   input  logic [31:0] rs2,
   output logic        busy,
   output logic        ready,
   output logic [31:0] rd
);

   if (!lanes_legal(LANES)) begin : g_lanes_check
      $error("aes_tiled_lanes: LANES must be 1, 2 or 4");
   end

   localparam logic [1:0] STEP = 2'(LANES);
   localparam logic [1:0] LAST = 2'(4 - LANES);

   state_t      state_q;
   logic [1:0]  cnt_q;
   logic [31:0] rs1_q, rs2_q, res_q, res_d, rd_q;
   op_t         op_q;
   logic        dec_q, hi_q;
   logic [7:0]  lane_byte [LANES];
   logic [1:0]  lane_pos  [LANES];

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [1:0] job;
      assign job = cnt_q + 2'(l);
      aes_tiled_lane #(.DECRYPT_EN(DECRYPT_EN)) u_lane (
         .rs1_i  (rs1_q),
         .rs2_i  (rs2_q),
         .op_i   (op_q),
         .dec_i  (dec_q),
         .hi_i   (hi_q),
         .job_i  (job),
         .byte_o (lane_byte[l]),
         .pos_o  (lane_pos[l])
      );
   end

   always_comb begin
      res_d = res_q;
      for (int l = 0; l < LANES; l++) res_d[8*lane_pos[l] +: 8] = lane_byte[l];
   end

   // Partial bytes collect in res_q so a flushed operation never disturbs rd.
   always_ff @(posedge g_clk) begin
      if (!g_resetn) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         rd_q    <= '0;
      end else if (flush) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            ST_BUSY: begin
               res_q <= res_d;
               cnt_q <= cnt_q + STEP;
               if (cnt_q == LAST) begin
                  rd_q    <= res_d;
                  state_q <= ST_DONE;
               end
            end
            default: begin
               if (valid) begin
                  rs1_q   <= rs1;
                  rs2_q   <= rs2;
                  op_q    <= op_decode(op_mix, op_sb, op_sbsr);
                  dec_q   <= dec & DECRYPT_EN;
                  hi_q    <= hi;
                  cnt_q   <= '0;
                  state_q <= ST_BUSY;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
         endcase
      end
   end

   assign busy  = (state_q == ST_BUSY);
   assign ready = (state_q == ST_DONE);
   assign rd    = rd_q;

endmodule

// File: tb/tb_aes_tiled_lanes.sv
// Bench for aes_tiled_lanes: four instances (LANES 1/2/4, plus LANES=1 without
// the inverse S-box) share one stimulus stream and are checked against a model.
module tb_aes_tiled_lanes;

   logic        g_clk, g_resetn, valid, flush, dec, op_sb, op_sbsr, op_mix, hi;
   logic [31:0] rs1, rs2;
   logic [3:0]        busy_w, ready_w;
   logic [3:0][31:0]  rd_w;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 0;

   logic [7:0] sbox  [256];
   logic [7:0] isbox [256];

   localparam logic [127:0] SROW [16] = '{
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   int exp_lat [4] = '{5, 3, 2, 5};

   always #5 g_clk = ~g_clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      aes_tiled_lanes #(
         .LANES      ((g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 1),
         .DECRYPT_EN ((g == 3) ? 1'b0 : 1'b1)
      ) u_dut (
         .g_clk    (g_clk),
         .g_resetn (g_resetn),
         .valid    (valid),
         .flush    (flush),
         .dec      (dec),
         .op_sb    (op_sb),
         .op_sbsr  (op_sbsr),
         .op_mix   (op_mix),
         .hi       (hi),
         .rs1      (rs1),
         .rs2      (rs2),
         .busy     (busy_w[g]),
         .ready    (ready_w[g]),
         .rd       (rd_w[g])
      );
   end

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 0; x = a; y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p ^= x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] mcol(input logic [31:0] c, input logic inv);
      if (inv)
         return gm(c[7:0], 14) ^ gm(c[15:8], 11) ^ gm(c[23:16], 13) ^ gm(c[31:24], 9);
      return gm(c[7:0], 2) ^ gm(c[15:8], 3) ^ c[23:16] ^ c[31:24];
   endfunction

   function automatic logic [31:0] model_rd(input logic [31:0] a, input logic [31:0] b,
                                            input logic sb, input logic mix,
                                            input logic d, input logic h);
      logic [7:0]  p [4];
      logic [7:0]  q [4];
      logic [31:0] ca, cb;
      for (int i = 0; i < 4; i++) begin
         p[i] = a[8*i +: 8];
         q[i] = b[8*i +: 8];
      end
      if (mix) begin
         ca = {p[2], p[3], q[2], q[3]};
         cb = {p[0], p[1], q[0], q[1]};
         return {mcol({ca[23:0], ca[31:24]}, d), mcol(ca, d),
                 mcol({cb[23:0], cb[31:24]}, d), mcol(cb, d)};
      end
      if (sb) return {sbox[p[3]], sbox[p[2]], sbox[p[1]], sbox[p[0]]};
      case ({d, h})
         2'b00:   return {sbox[p[1]], sbox[p[2]], sbox[q[3]], sbox[p[0]]};
         2'b01:   return {sbox[q[1]], sbox[q[2]], sbox[p[3]], sbox[q[0]]};
         2'b10:   return {isbox[q[1]], isbox[p[2]], isbox[p[3]], isbox[p[0]]};
         default: return {isbox[p[1]], isbox[q[2]], isbox[q[3]], isbox[q[0]]};
      endcase
   endfunction

   task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", nm, act, exp);
      end
   endtask

   // Model: cycles left in flight per instance, result strobe and held result.
   int          m_left [4];
   logic        m_rdy  [4];
   logic [31:0] m_rd   [4];
   logic [31:0] m_pend [4];

   always @(posedge g_clk) begin
      for (int k = 0; k < 4; k++) begin
         if (!g_resetn) begin
            m_left[k] <= 0;
            m_rdy[k]  <= 1'b0;
            m_rd[k]   <= 32'h0;
         end else if (flush) begin
            m_left[k] <= 0;
            m_rdy[k]  <= 1'b0;
         end else if (m_left[k] > 0) begin
            m_left[k] <= m_left[k] - 1;
            m_rdy[k]  <= (m_left[k] == 1);
            if (m_left[k] == 1) m_rd[k] <= m_pend[k];
         end else begin
            m_rdy[k] <= 1'b0;
            if (valid) begin
               m_pend[k] <= model_rd(rs1, rs2, op_sb, op_mix, dec & (k != 3), hi);
               m_left[k] <= exp_lat[k] - 1;
            end
         end
      end
   end

   always @(negedge g_clk) begin
      if (chk_en) begin
         for (int k = 0; k < 4; k++) begin
            check32($sformatf("busy[%0d]", k), 32'(busy_w[k]), 32'(m_left[k] != 0));
            check32($sformatf("ready[%0d]", k), 32'(ready_w[k]), 32'(m_rdy[k]));
            check32($sformatf("rd[%0d]", k), rd_w[k], m_rd[k]);
         end
      end
   end

   task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sb,
                        input logic sbsr, input logic mix, input logic d, input logic h,
                        input bit use_lit, input logic [31:0] lit, input logic [31:0] lit3);
      int lat [4];
      lat = '{0, 0, 0, 0};
      @(posedge g_clk); #1;
      rs1 = a; rs2 = b; op_sb = sb; op_sbsr = sbsr; op_mix = mix; dec = d; hi = h;
      valid = 1'b1;
      @(posedge g_clk); #1;
      valid = 1'b0;
      rs1 = $urandom;
      rs2 = $urandom;
      for (int c = 1; c <= 6; c++) begin
         @(negedge g_clk);
         for (int k = 0; k < 4; k++)
            if (ready_w[k] === 1'b1 && lat[k] == 0) lat[k] = c;
      end
      for (int k = 0; k < 4; k++)
         check32($sformatf("latency[%0d]", k), 32'(lat[k]), 32'(exp_lat[k]));
      if (use_lit) begin
         for (int k = 0; k < 3; k++) check32($sformatf("lit rd[%0d]", k), rd_w[k], lit);
         check32("lit rd[3] nodec", rd_w[3], lit3);
      end
   endtask

   initial begin
      int nrdy;
      logic [2:0] ob;
      for (int r = 0; r < 16; r++)
         for (int c = 0; c < 16; c++) sbox[r*16+c] = SROW[r][127-8*c -: 8];
      for (int i = 0; i < 256; i++) isbox[sbox[i]] = 8'(i);

      g_clk = 0; g_resetn = 0; valid = 0; flush = 0; dec = 0;
      op_sb = 0; op_sbsr = 0; op_mix = 0; hi = 0; rs1 = 0; rs2 = 0;
      repeat (2) @(posedge g_clk);
      #1 g_resetn = 1;
      @(negedge g_clk);
      for (int k = 0; k < 4; k++) begin
         check32($sformatf("reset busy[%0d]", k), 32'(busy_w[k]), 32'h0);
         check32($sformatf("reset ready[%0d]", k), 32'(ready_w[k]), 32'h0);
         check32($sformatf("reset rd[%0d]", k), rd_w[k], 32'h0);
      end
      chk_en = 1;

      do_op(32'h00530001, 32'h0, 1, 0, 0, 0, 0, 1, 32'h63ED637C, 32'h63ED637C);
      do_op(32'h0, 32'h53000000, 0, 1, 0, 0, 0, 1, 32'h6363ED63, 32'h6363ED63);
      do_op(32'h63636363, 32'h63636363, 0, 1, 0, 1, 1, 1, 32'h00000000, 32'hFBFBFBFB);
      do_op(32'h01010101, 32'h01010101, 0, 0, 1, 0, 0, 1, 32'h01010101, 32'h01010101);
      do_op(32'h01010101, 32'h01010101, 0, 0, 1, 1, 0, 1, 32'h01010101, 32'h01010101);
      do_op(32'h00005345, 32'h0000db13, 0, 0, 1, 0, 0, 0, 0, 0);
      check32("mix fwd byte0", 32'(rd_w[0][7:0]), 32'h8e);
      do_op(32'h0000a1bc, 32'h00008e4d, 0, 0, 1, 1, 0, 0, 0, 0);
      check32("mix inv byte0", 32'(rd_w[0][7:0]), 32'hdb);

      for (int i = 0; i < 10; i++) begin
         ob = 3'($urandom);
         do_op($urandom, $urandom, ob[0], ob[1], ob[2], 1'($urandom), 1'($urandom), 0, 0, 0);
      end

      // valid held high with operands changing every cycle
      nrdy = 0;
      @(posedge g_clk); #1;
      op_sb = 1; op_sbsr = 0; op_mix = 0; dec = 0; hi = 0;
      rs1 = $urandom; rs2 = $urandom; valid = 1;
      for (int i = 0; i < 20; i++) begin
         @(posedge g_clk); #1;
         rs1 = $urandom;
         @(negedge g_clk);
         if (ready_w[2] === 1'b1) nrdy++;
      end
      valid = 0;
      check32("b2b ready count L4", 32'(nrdy), 32'd10);
      repeat (8) @(negedge g_clk);

      // flush in the second BUSY cycle together with valid
      do_op(32'h00530001, 32'h0, 1, 0, 0, 0, 0, 1, 32'h63ED637C, 32'h63ED637C);
      @(posedge g_clk); #1;
      rs1 = 32'h01010101; op_sb = 1; op_sbsr = 0; op_mix = 0; dec = 0; valid = 1;
      @(posedge g_clk); #1;
      valid = 0;
      @(posedge g_clk); #1;
      valid = 1; flush = 1;
      @(posedge g_clk); #1;
      valid = 0; flush = 0;
      @(negedge g_clk);
      check32("flush busy[0]", 32'(busy_w[0]), 32'h0);
      check32("flush ready[0]", 32'(ready_w[0]), 32'h0);
      check32("flush rd[0]", rd_w[0], 32'h63ED637C);
      check32("flush rd[1]", rd_w[1], 32'h63ED637C);
      check32("flush ready[2]", 32'(ready_w[2]), 32'h0);
      repeat (6) @(negedge g_clk);
      do_op(32'h01010101, 32'h0, 1, 0, 0, 0, 0, 1, 32'h7C7C7C7C, 32'h7C7C7C7C);

      // reset in the middle of BUSY
      @(posedge g_clk); #1;
      rs1 = 32'h00530001; op_sb = 1; valid = 1;
      @(posedge g_clk); #1;
      valid = 0;
      @(posedge g_clk); #1;
      g_resetn = 0;
      @(posedge g_clk); #1;
      @(negedge g_clk);
      for (int k = 0; k < 4; k++) begin
         check32($sformatf("rst busy[%0d]", k), 32'(busy_w[k]), 32'h0);
         check32($sformatf("rst ready[%0d]", k), 32'(ready_w[k]), 32'h0);
         check32($sformatf("rst rd[%0d]", k), rd_w[k], 32'h0);
      end
      g_resetn = 1;
      repeat (4) @(negedge g_clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
